// File: rtl/arch_defs_pkg.sv
// Shared SAP-2 architecture definitions: ALU ops, opcodes,
// T-step constants and the control strobe bundle.
package arch_defs_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam int STEP_WIDTH   = 3;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_STA = 4'h6,
    OP_LDI = 4'h7,
    OP_JMP = 4'h8,
    OP_JC  = 4'h9,
    OP_JZ  = 4'hA,
    OP_JN  = 4'hB,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  localparam logic [STEP_WIDTH-1:0] T0 = 3'd0;
  localparam logic [STEP_WIDTH-1:0] T1 = 3'd1;
  localparam logic [STEP_WIDTH-1:0] T2 = 3'd2;
  localparam logic [STEP_WIDTH-1:0] T3 = 3'd3;
  localparam logic [STEP_WIDTH-1:0] T4 = 3'd4;
  localparam logic [STEP_WIDTH-1:0] T5 = 3'd5;

  typedef struct packed {
    logic pc_enable;
    logic load_pc;
    logic oe_pc;
    logic load_mar;
    logic oe_ram;
    logic ram_we;
    logic load_ir;
    logic oe_ir;
    logic load_a;
    logic oe_a;
    logic load_b;
    logic oe_alu;
    logic load_o;
  } ctrl_t;

  function automatic logic is_alu(opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction

  function automatic alu_op_t alu_of(opcode_t op);
    alu_op_t r;
    r = ALU_ADD;
    unique case (op)
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_OR:   r = ALU_OR;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cu_flags_reg.sv
// Architectural z/c/n flags register with load enable
// and synchronous active-low reset.
module cu_flags_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] d,
  output logic [2:0] q
);

  always_ff @(posedge clk) begin
    if (!reset)
      q <= 3'b000;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/control_unit.sv
// SAP-2 microcoded sequencer: T-step counter, halt bit,
// flags register and Moore decode of the control strobes.
module control_unit
  import arch_defs_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    alu_zero,
  input  logic                    alu_carry,
  input  logic                    alu_negative,
  output logic [1:0]              alu_op,
  output logic                    pc_enable,
  output logic                    load_pc,
  output logic                    oe_pc,
  output logic                    load_mar,
  output logic                    oe_ram,
  output logic                    ram_we,
  output logic                    load_ir,
  output logic                    oe_ir,
  output logic                    load_a,
  output logic                    oe_a,
  output logic                    load_b,
  output logic                    oe_alu,
  output logic                    load_o,
  output logic                    halt,
  output logic [STEP_WIDTH-1:0]   step,
  output logic                    flag_z,
  output logic                    flag_c,
  output logic                    flag_n
);

  logic [STEP_WIDTH-1:0] step_q;
  logic                  halt_q;
  logic [2:0]            flags_q;
  opcode_t               op;
  ctrl_t                 c;
  alu_op_t               aop;
  logic                  last;
  logic                  set_halt;
  logic                  flag_load;
  logic                  run;

  assign op  = opcode_t'(opcode);
  assign run = reset && !halt_q;

  always_comb begin
    c         = '0;
    aop       = ALU_ADD;
    last      = 1'b0;
    set_halt  = 1'b0;
    flag_load = 1'b0;
    if (run) begin
      unique case (step_q)
        T0: begin
          c.oe_pc    = 1'b1;
          c.load_mar = 1'b1;
        end
        T1: begin
          c.oe_ram    = 1'b1;
          c.load_ir   = 1'b1;
          c.pc_enable = 1'b1;
        end
        T2: begin
          last = 1'b1;
          unique case (op)
            OP_LDA, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_STA: begin
              c.oe_ir    = 1'b1;
              c.load_mar = 1'b1;
              last       = 1'b0;
            end
            OP_LDI: begin
              c.oe_ir  = 1'b1;
              c.load_a = 1'b1;
            end
            OP_JMP: begin
              c.oe_ir   = 1'b1;
              c.load_pc = 1'b1;
            end
            OP_JC: begin
              c.oe_ir   = flags_q[1];
              c.load_pc = flags_q[1];
            end
            OP_JZ: begin
              c.oe_ir   = flags_q[2];
              c.load_pc = flags_q[2];
            end
            OP_JN: begin
              c.oe_ir   = flags_q[0];
              c.load_pc = flags_q[0];
            end
            OP_OUT: begin
              c.oe_a   = 1'b1;
              c.load_o = 1'b1;
            end
            OP_HLT:  set_halt = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          last = 1'b1;
          unique case (op)
            OP_LDA: begin
              c.oe_ram = 1'b1;
              c.load_a = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              c.oe_ram = 1'b1;
              c.load_b = 1'b1;
              last     = 1'b0;
            end
            OP_STA: begin
              c.oe_a   = 1'b1;
              c.ram_we = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (is_alu(op))
            aop = alu_of(op);
          else
            last = 1'b1;
        end
        T5: begin
          last = 1'b1;
          if (is_alu(op)) begin
            aop       = alu_of(op);
            c.oe_alu  = 1'b1;
            c.load_a  = 1'b1;
            flag_load = 1'b1;
          end
        end
        default: last = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      step_q <= T0;
      halt_q <= 1'b0;
    end else if (halt_q) begin
      step_q <= T0;
    end else if (last) begin
      step_q <= T0;
      halt_q <= set_halt;
    end else begin
      step_q <= step_q + 1'b1;
    end
  end

  cu_flags_reg u_flags (
    .clk   (clk),
    .reset (reset),
    .load  (flag_load),
    .d     ({alu_zero, alu_carry, alu_negative}),
    .q     (flags_q)
  );

  assign alu_op    = aop;
  assign pc_enable = c.pc_enable;
  assign load_pc   = c.load_pc;
  assign oe_pc     = c.oe_pc;
  assign load_mar  = c.load_mar;
  assign oe_ram    = c.oe_ram;
  assign ram_we    = c.ram_we;
  assign load_ir   = c.load_ir;
  assign oe_ir     = c.oe_ir;
  assign load_a    = c.load_a;
  assign oe_a      = c.oe_a;
  assign load_b    = c.load_b;
  assign oe_alu    = c.oe_alu;
  assign load_o    = c.load_o;
  assign halt      = halt_q;
  assign step      = step_q;
  assign flag_z    = flags_q[2];
  assign flag_c    = flags_q[1];
  assign flag_n    = flags_q[0];

endmodule

// File: tb/tb_control_unit.sv
// Directed table-driven bench for the SAP-2 control unit,
// plus hand sequences for halt and mid-instruction reset.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       alu_zero, alu_carry, alu_negative;
  logic [1:0] alu_op;
  logic       pc_enable, load_pc, oe_pc, load_mar, oe_ram;
  logic       ram_we, load_ir, oe_ir, load_a, oe_a, load_b;
  logic       oe_alu, load_o, halt;
  logic [2:0] step;
  logic       flag_z, flag_c, flag_n;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_negative(alu_negative), .alu_op(alu_op),
    .pc_enable(pc_enable), .load_pc(load_pc), .oe_pc(oe_pc),
    .load_mar(load_mar), .oe_ram(oe_ram), .ram_we(ram_we),
    .load_ir(load_ir), .oe_ir(oe_ir), .load_a(load_a),
    .oe_a(oe_a), .load_b(load_b), .oe_alu(oe_alu),
    .load_o(load_o), .halt(halt), .step(step),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
  );

  // strobe vector bit order: pc_en load_pc oe_pc load_mar oe_ram
  // ram_we load_ir oe_ir load_a oe_a load_b oe_alu load_o
  localparam logic [12:0] PCE = 13'h1000, LPC = 13'h0800;
  localparam logic [12:0] OPC = 13'h0400, MAR = 13'h0200;
  localparam logic [12:0] RAM = 13'h0100, WE  = 13'h0080;
  localparam logic [12:0] LIR = 13'h0040, OIR = 13'h0020;
  localparam logic [12:0] LA  = 13'h0010, OA  = 13'h0008;
  localparam logic [12:0] LB  = 13'h0004, OAL = 13'h0002;
  localparam logic [12:0] LO  = 13'h0001, NONE = 13'h0000;
  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1;
  localparam logic [1:0] AND = 2'd2, OR = 2'd3;

  logic [12:0] sb;
  assign sb = {pc_enable, load_pc, oe_pc, load_mar, oe_ram,
               ram_we, load_ir, oe_ir, load_a, oe_a, load_b,
               oe_alu, load_o};

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  zcn;
    logic [2:0]  st;
    logic [12:0] sb;
    logic [1:0]  ao;
    logic [2:0]  fl;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] op, input logic [2:0] zcn,
                     input logic [2:0] st, input logic [12:0] s,
                     input logic [1:0] ao, input logic [2:0] fl);
    vec_t v;
    v.op = op; v.zcn = zcn; v.st = st;
    v.sb = s; v.ao = ao; v.fl = fl;
    vq.push_back(v);
  endtask

  task automatic fetch(input logic [3:0] op, input logic [2:0] zcn,
                       input logic [2:0] fl);
    add(op, zcn, 3'd0, OPC | MAR, ADD, fl);
    add(op, zcn, 3'd1, RAM | LIR | PCE, ADD, fl);
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] op, input logic [2:0] zcn);
    opcode = op;
    {alu_zero, alu_carry, alu_negative} = zcn;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] g;
    reset = 1'b0;
    set_in(4'h0, 3'b000);

    // SUB 8-3: z=0 c=1 n=0
    fetch(4'h3, 3'b010, 3'b000);
    add(4'h3, 3'b010, 3'd2, OIR | MAR, ADD, 3'b000);
    add(4'h3, 3'b010, 3'd3, RAM | LB,  ADD, 3'b000);
    add(4'h3, 3'b010, 3'd4, NONE,      SUB, 3'b000);
    add(4'h3, 3'b010, 3'd5, OAL | LA,  SUB, 3'b000);
    g = 3'b101;  // ALU flag noise that must never be captured
    fetch(4'h9, g, 3'b010);
    add(4'h9, g, 3'd2, OIR | LPC, ADD, 3'b010);
    fetch(4'hA, g, 3'b010);
    add(4'hA, g, 3'd2, NONE, ADD, 3'b010);
    fetch(4'hB, g, 3'b010);
    add(4'hB, g, 3'd2, NONE, ADD, 3'b010);
    fetch(4'h6, g, 3'b010);
    add(4'h6, g, 3'd2, OIR | MAR, ADD, 3'b010);
    add(4'h6, g, 3'd3, OA | WE,   ADD, 3'b010);
    fetch(4'h1, g, 3'b010);
    add(4'h1, g, 3'd2, OIR | MAR, ADD, 3'b010);
    add(4'h1, g, 3'd3, RAM | LA,  ADD, 3'b010);
    fetch(4'h7, g, 3'b010);
    add(4'h7, g, 3'd2, OIR | LA, ADD, 3'b010);
    fetch(4'hE, g, 3'b010);
    add(4'hE, g, 3'd2, OA | LO, ADD, 3'b010);
    fetch(4'h0, g, 3'b010);
    add(4'h0, g, 3'd2, NONE, ADD, 3'b010);
    fetch(4'hC, g, 3'b010);
    add(4'hC, g, 3'd2, NONE, ADD, 3'b010);
    fetch(4'hD, g, 3'b010);
    add(4'hD, g, 3'd2, NONE, ADD, 3'b010);
    fetch(4'h8, g, 3'b010);
    add(4'h8, g, 3'd2, OIR | LPC, ADD, 3'b010);
    // ADD giving zero: flags -> z
    fetch(4'h2, 3'b100, 3'b010);
    add(4'h2, 3'b100, 3'd2, OIR | MAR, ADD, 3'b010);
    add(4'h2, 3'b100, 3'd3, RAM | LB,  ADD, 3'b010);
    add(4'h2, 3'b100, 3'd4, NONE,      ADD, 3'b010);
    add(4'h2, 3'b100, 3'd5, OAL | LA,  ADD, 3'b010);
    fetch(4'hA, g, 3'b100);
    add(4'hA, g, 3'd2, OIR | LPC, ADD, 3'b100);
    fetch(4'h9, g, 3'b100);
    add(4'h9, g, 3'd2, NONE, ADD, 3'b100);
    // OR giving negative: flags -> n
    fetch(4'h5, 3'b001, 3'b100);
    add(4'h5, 3'b001, 3'd2, OIR | MAR, ADD, 3'b100);
    add(4'h5, 3'b001, 3'd3, RAM | LB,  ADD, 3'b100);
    add(4'h5, 3'b001, 3'd4, NONE,      OR,  3'b100);
    add(4'h5, 3'b001, 3'd5, OAL | LA,  OR,  3'b100);
    fetch(4'hB, g, 3'b001);
    add(4'hB, g, 3'd2, OIR | LPC, ADD, 3'b001);
    fetch(4'hA, g, 3'b001);
    add(4'hA, g, 3'd2, NONE, ADD, 3'b001);
    // AND: flags -> z,c
    fetch(4'h4, 3'b110, 3'b001);
    add(4'h4, 3'b110, 3'd2, OIR | MAR, ADD, 3'b001);
    add(4'h4, 3'b110, 3'd3, RAM | LB,  ADD, 3'b001);
    add(4'h4, 3'b110, 3'd4, NONE,      AND, 3'b001);
    add(4'h4, 3'b110, 3'd5, OAL | LA,  AND, 3'b001);
    fetch(4'h9, g, 3'b110);
    add(4'h9, g, 3'd2, OIR | LPC, ADD, 3'b110);

    // reset held for two cycles
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_strobes", {19'd0, sb}, 32'd0);
      chk("rst_halt_step", {28'd0, halt, step}, 32'd0);
      next_cycle();
    end
    reset = 1'b1;

    foreach (vq[i]) begin
      set_in(vq[i].op, vq[i].zcn);
      @(negedge clk);
      tests++;
      if ({step, sb, alu_op, halt, flag_z, flag_c, flag_n} !==
          {vq[i].st, vq[i].sb, vq[i].ao, 1'b0, vq[i].fl}) begin
        fails++;
        $display("FAIL vec%0d op=%h: got st=%0d sb=%h ao=%0d h=%b f=%b%b%b expected st=%0d sb=%h ao=%0d h=0 f=%b",
                 i, vq[i].op, step, sb, alu_op, halt, flag_z,
                 flag_c, flag_n, vq[i].st, vq[i].sb, vq[i].ao,
                 vq[i].fl);
      end
      next_cycle();
    end

    // HLT
    set_in(4'hF, 3'b000);
    @(negedge clk); chk("hlt_t0", {29'd0, step}, 32'd0);
    next_cycle();
    @(negedge clk); chk("hlt_t1", {29'd0, step}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("hlt_t2", {16'd0, step, sb}, {16'd0, 3'd2, NONE});
    chk("hlt_t2_halt", {31'd0, halt}, 32'd0);
    next_cycle();
    for (int i = 0; i < 11; i++) begin
      set_in(4'h3, 3'b111);
      @(negedge clk);
      chk("halted", {15'd0, halt, step, sb}, {15'd0, 1'b1, 3'd0, NONE});
      chk("halted_flags", {29'd0, flag_z, flag_c, flag_n}, 32'd6);
      next_cycle();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("hlt_rst_strobes", {19'd0, sb}, 32'd0);
    next_cycle();
    reset = 1'b1;
    set_in(4'h0, 3'b000);
    @(negedge clk);
    chk("hlt_exit", {15'd0, halt, step, sb}, {15'd0, 1'b0, 3'd0, OPC | MAR});
    chk("hlt_exit_flags", {29'd0, flag_z, flag_c, flag_n}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("hlt_exit_t1", {16'd0, step, sb}, {16'd0, 3'd1, RAM | LIR | PCE});
    next_cycle();
    @(negedge clk);
    next_cycle();

    // SUB to set carry, then ADD aborted by reset in T3
    for (int i = 0; i < 6; i++) begin
      set_in(4'h3, 3'b010);
      next_cycle();
    end
    set_in(4'h2, 3'b111);
    @(negedge clk);
    chk("pre_abort_flags", {29'd0, flag_z, flag_c, flag_n}, 32'd2);
    for (int i = 0; i < 3; i++) next_cycle();
    @(negedge clk);
    chk("abort_t3", {16'd0, step, sb}, {16'd0, 3'd3, RAM | LB});
    #1;
    reset = 1'b0;
    #1;
    chk("abort_forced0", {19'd0, sb}, 32'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_step", {16'd0, step, sb}, {16'd0, 3'd0, OPC | MAR});
    chk("abort_flags", {29'd0, flag_z, flag_c, flag_n}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      set_in(4'h0, 3'b111);
      next_cycle();
      @(negedge clk);
      chk("abort_no_load_a", {31'd0, load_a}, 32'd0);
    end
    chk("abort_flags_kept", {29'd0, flag_z, flag_c, flag_n}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
